// File: rtl/pacman_pkg.sv
// pacman_pkg: shared direction codes, ghost modes and maze geometry
package pacman_pkg;
  typedef enum logic [7:0] {
    DIR_STOP  = 8'h00,
    DIR_LEFT  = 8'h04,
    DIR_RIGHT = 8'h07,
    DIR_DOWN  = 8'h16,
    DIR_UP    = 8'h1A
  } dir_t;
  typedef enum logic [1:0] {MODE_IDLE, MODE_SCATTER, MODE_CHASE, MODE_FRIGHT} ghost_mode_t;
  localparam logic [9:0] X_MIN = 10'd7;
  localparam logic [9:0] X_MAX = 10'd396;
  localparam logic [9:0] Y_MIN = 10'd7;
  localparam logic [9:0] Y_MAX = 10'd440;
  localparam logic [9:0] GHOST_SIZE = 10'd10;
  localparam int TILE_LOG2 = 3;
  function automatic dir_t reverse_dir(dir_t d);
    return d == DIR_LEFT ? DIR_RIGHT : d == DIR_RIGHT ? DIR_LEFT :
           d == DIR_UP ? DIR_DOWN : d == DIR_DOWN ? DIR_UP : DIR_STOP;
  endfunction
endpackage

// File: rtl/ghost_dir_select.sv
// ghost_dir_select: combinational choice of the next legal ghost direction
module ghost_dir_select import pacman_pkg::*; (
  input  logic [9:0] ghost_x,
  input  logic [9:0] ghost_y,
  input  logic [9:0] target_x,
  input  logic [9:0] target_y,
  input  dir_t       cur_dir,
  input  logic       fright,
  input  logic [1:0] rnd,
  output dir_t       next_dir
);
  function automatic dir_t scan_dir(logic [1:0] i);
    return i == 2'd0 ? DIR_UP : i == 2'd1 ? DIR_LEFT : i == 2'd2 ? DIR_DOWN : DIR_RIGHT;
  endfunction
  function automatic logic [1:0] scan_idx(dir_t d);
    return d == DIR_UP ? 2'd0 : d == DIR_LEFT ? 2'd1 : d == DIR_DOWN ? 2'd2 : 2'd3;
  endfunction
  function automatic logic legal(dir_t d, logic [3:0] open, dir_t cur);
    return d != reverse_dir(cur) && open[scan_idx(d)];
  endfunction
  logic [3:0] open_dir;
  logic signed [10:0] dx, dy;
  logic [10:0] adx, ady;
  dir_t prim, sec, cand;
  // bits follow the scan order {right, down, left, up}
  assign open_dir = {ghost_x < X_MAX - GHOST_SIZE, ghost_y < Y_MAX - GHOST_SIZE,
                     ghost_x > X_MIN + GHOST_SIZE, ghost_y > Y_MIN + GHOST_SIZE};
  assign dx = $signed({1'b0, target_x}) - $signed({1'b0, ghost_x});
  assign dy = $signed({1'b0, target_y}) - $signed({1'b0, ghost_y});
  assign adx = dx[10] ? 11'(-dx) : 11'(dx);
  assign ady = dy[10] ? 11'(-dy) : 11'(dy);
  assign prim = adx >= ady ? (dx[10] ? DIR_LEFT : DIR_RIGHT) : (dy[10] ? DIR_UP : DIR_DOWN);
  assign sec = adx >= ady ? (dy[10] ? DIR_UP : DIR_DOWN) : (dx[10] ? DIR_LEFT : DIR_RIGHT);
  // later assignments win, so entries are visited from lowest to highest priority
  always_comb begin
    next_dir = reverse_dir(cur_dir);
    cand = DIR_STOP;
    for (int i = 3; i >= 0; i--) begin
      cand = scan_dir(fright ? rnd + 2'(i) : 2'(i));
      if (legal(cand, open_dir, cur_dir)) next_dir = cand;
    end
    if (!fright && legal(sec, open_dir, cur_dir)) next_dir = sec;
    if (!fright && legal(prim, open_dir, cur_dir)) next_dir = prim;
  end
endmodule

// File: rtl/ghost_ctrl.sv
// ghost_ctrl: ghost mode sequencer and per-frame direction scheduler
module ghost_ctrl import pacman_pkg::*; #(
  parameter int         SCATTER_FRAMES = 420,
  parameter int         CHASE_FRAMES   = 1200,
  parameter int         FRIGHT_FRAMES  = 360,
  parameter logic [9:0] CORNER_X       = 10'd396,
  parameter logic [9:0] CORNER_Y       = 10'd7
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       start,
  input  logic       power_pellet,
  input  logic [9:0] pacX,
  input  logic [9:0] pacY,
  input  logic [9:0] ghostX,
  input  logic [9:0] ghostY,
  output logic [7:0] dir_code,
  output logic [1:0] mode,
  output logic       fright_active
);
  localparam logic [15:0] SC_LOAD = 16'(SCATTER_FRAMES - 1);
  localparam logic [15:0] CH_LOAD = 16'(CHASE_FRAMES - 1);
  localparam logic [15:0] FR_LOAD = 16'(FRIGHT_FRAMES - 1);
  ghost_mode_t mode_r, mode_n;
  dir_t dir_r, dir_n, sel_dir;
  logic [15:0] timer, timer_n;
  logic rev_pend, rev_n, mode_chg, at_tile;
  logic [7:0] lfsr;
  assign mode = mode_r;
  assign dir_code = dir_r;
  assign at_tile = ghostX[TILE_LOG2-1:0] == '0 && ghostY[TILE_LOG2-1:0] == '0;
  ghost_dir_select u_sel (
    .ghost_x  (ghostX),
    .ghost_y  (ghostY),
    .target_x (mode_r == MODE_SCATTER ? CORNER_X : pacX),
    .target_y (mode_r == MODE_SCATTER ? CORNER_Y : pacY),
    .cur_dir  (dir_r),
    .fright   (mode_r == MODE_FRIGHT),
    .rnd      (lfsr[1:0]),
    .next_dir (sel_dir)
  );
  always_comb begin
    mode_n = mode_r;
    timer_n = timer - 16'd1;
    mode_chg = 1'b0;
    if (mode_r == MODE_IDLE) begin
      timer_n = start ? SC_LOAD : timer;
      mode_n = start ? MODE_SCATTER : MODE_IDLE;
    end else if (power_pellet) begin
      mode_n = MODE_FRIGHT;
      timer_n = FR_LOAD;
      mode_chg = mode_r != MODE_FRIGHT;
    end else if (timer == '0) begin
      mode_n = mode_r == MODE_CHASE ? MODE_SCATTER : MODE_CHASE;
      timer_n = mode_r == MODE_CHASE ? SC_LOAD : CH_LOAD;
      mode_chg = mode_r != MODE_FRIGHT;
    end
    dir_n = dir_r;
    rev_n = rev_pend;
    if (mode_r == MODE_IDLE) dir_n = start ? DIR_LEFT : DIR_STOP;
    else if (at_tile) begin
      dir_n = rev_pend ? reverse_dir(dir_r) : sel_dir;
      rev_n = 1'b0;
    end
    if (mode_chg) rev_n = 1'b1;
  end
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      mode_r <= MODE_IDLE;
      dir_r <= DIR_STOP;
      timer <= '0;
      rev_pend <= 1'b0;
      fright_active <= 1'b0;
      lfsr <= 8'hA5;
    end else begin
      mode_r <= mode_n;
      dir_r <= dir_n;
      timer <= timer_n;
      rev_pend <= rev_n;
      fright_active <= mode_n == MODE_FRIGHT;
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end
endmodule

// File: tb/tb_ghost_ctrl.sv
// tb_ghost_ctrl: scoreboard bench for the ghost mode sequencer and direction picker
module tb_ghost_ctrl;
  logic frame_clk = 1'b0;
  logic Reset, start, power_pellet;
  logic [9:0] pacX, pacY, ghostX, ghostY;
  logic [7:0] dir_code;
  logic [1:0] mode;
  logic fright_active;
  typedef struct {
    logic [10:0] v;
    string n;
  } sb_t;
  sb_t sb[$];
  int n_chk = 0;
  int n_pass = 0;

  ghost_ctrl #(.SCATTER_FRAMES(4), .CHASE_FRAMES(6)) dut (
    .frame_clk     (frame_clk),
    .Reset         (Reset),
    .start         (start),
    .power_pellet  (power_pellet),
    .pacX          (pacX),
    .pacY          (pacY),
    .ghostX        (ghostX),
    .ghostY        (ghostY),
    .dir_code      (dir_code),
    .mode          (mode),
    .fright_active (fright_active)
  );

  always #5 frame_clk = ~frame_clk;

  function automatic logic [10:0] ex(logic [1:0] m, logic [7:0] d, logic f);
    return {m, d, f};
  endfunction

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic push(input logic [10:0] v, input string n);
    sb_t e;
    e.v = v;
    e.n = n;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    sb_t e;
    for (int i = 0; i < 4; i++) begin
      Reset = i < 2;
      start = i == 3;
      push(i == 3 ? ex(2'd1, 8'h04, 1'b0) : ex(2'd0, 8'h00, 1'b0), $sformatf("reset_%0d", i));
      tick();
      e = sb.pop_front();
      n_chk++;
      if ({mode, dir_code, fright_active} !== e.v)
        $display("FAIL %s: got mode/dir/fr %h/%h/%b want %h/%h/%b", e.n, mode, dir_code, fright_active, e.v[10:9], e.v[8:1], e.v[0]);
      else n_pass++;
    end
  endtask

  task automatic test_mode_cycle();
    sb_t e;
    start = 1'b0;
    for (int i = 0; i < 11; i++) begin
      ghostX = (i == 4 || i == 10) ? 10'd48 : 10'd49;
      ghostY = 10'd48;
      push(ex(i < 3 ? 2'd1 : i < 9 ? 2'd2 : 2'd1, i < 4 ? 8'h04 : i < 10 ? 8'h07 : 8'h04, 1'b0),
           $sformatf("mode_cycle_%0d", i));
      tick();
      e = sb.pop_front();
      n_chk++;
      if ({mode, dir_code, fright_active} !== e.v)
        $display("FAIL %s: got mode/dir/fr %h/%h/%b want %h/%h/%b", e.n, mode, dir_code, fright_active, e.v[10:9], e.v[8:1], e.v[0]);
      else n_pass++;
    end
  endtask

  task automatic test_chase_greedy();
    sb_t e;
    for (int i = 0; i < 6; i++) begin
      ghostX = i >= 3 ? 10'd48 : 10'd49;
      ghostY = 10'd48;
      pacX = i == 4 ? 10'd200 : 10'd48;
      pacY = i == 4 ? 10'd60 : 10'd300;
      push(ex(i < 2 ? 2'd1 : 2'd2, i < 3 ? 8'h04 : i < 5 ? 8'h07 : 8'h16, 1'b0), $sformatf("chase_greedy_%0d", i));
      tick();
      e = sb.pop_front();
      n_chk++;
      if ({mode, dir_code, fright_active} !== e.v)
        $display("FAIL %s: got mode/dir/fr %h/%h/%b want %h/%h/%b", e.n, mode, dir_code, fright_active, e.v[10:9], e.v[8:1], e.v[0]);
      else n_pass++;
    end
  endtask

  task automatic test_border();
    sb_t e;
    for (int i = 0; i < 2; i++) begin
      ghostX = i == 0 ? 10'd48 : 10'd16;
      ghostY = 10'd48;
      pacX = 10'd0;
      pacY = i == 0 ? 10'd48 : 10'd40;
      push(ex(2'd2, i == 0 ? 8'h04 : 8'h1A, 1'b0), $sformatf("border_%0d", i));
      tick();
      e = sb.pop_front();
      n_chk++;
      if ({mode, dir_code, fright_active} !== e.v)
        $display("FAIL %s: got mode/dir/fr %h/%h/%b want %h/%h/%b", e.n, mode, dir_code, fright_active, e.v[10:9], e.v[8:1], e.v[0]);
      else n_pass++;
    end
  endtask

  // a pellet at frame 0 and frame 100 keeps FRIGHT for 100+360 frames
  task automatic test_fright();
    sb_t e;
    pacX = 10'd48;
    pacY = 10'd300;
    for (int i = 0; i < 462; i++) begin
      power_pellet = i == 0 || i == 100;
      ghostX = (i == 1 || i == 461) ? 10'd48 : i == 50 ? 10'd16 : 10'd49;
      ghostY = i == 50 ? 10'd432 : 10'd48;
      push(ex(i < 460 ? 2'd3 : 2'd2, i == 0 ? 8'h1A : i < 50 ? 8'h16 : i < 461 ? 8'h07 : 8'h16, i < 460),
           $sformatf("fright_%0d", i));
      tick();
      e = sb.pop_front();
      n_chk++;
      if ({mode, dir_code, fright_active} !== e.v)
        $display("FAIL %s: got mode/dir/fr %h/%h/%b want %h/%h/%b", e.n, mode, dir_code, fright_active, e.v[10:9], e.v[8:1], e.v[0]);
      else n_pass++;
    end
    power_pellet = 1'b0;
  endtask

  task automatic test_reset_mid();
    sb_t e;
    for (int i = 0; i < 7; i++) begin
      power_pellet = i == 0 || i == 4;
      Reset = i == 4;
      start = i == 4 || i == 6;
      ghostX = i == 6 ? 10'd48 : 10'd49;
      ghostY = 10'd48;
      push(i < 4 ? ex(2'd3, 8'h16, 1'b1) : i < 6 ? ex(2'd0, 8'h00, 1'b0) : ex(2'd1, 8'h04, 1'b0),
           $sformatf("reset_mid_%0d", i));
      tick();
      e = sb.pop_front();
      n_chk++;
      if ({mode, dir_code, fright_active} !== e.v)
        $display("FAIL %s: got mode/dir/fr %h/%h/%b want %h/%h/%b", e.n, mode, dir_code, fright_active, e.v[10:9], e.v[8:1], e.v[0]);
      else n_pass++;
      if (i == 4) begin
        n_chk++;
        if (dut.lfsr !== 8'hA5) $display("FAIL reset_mid_lfsr: got %h want a5", dut.lfsr);
        else n_pass++;
      end
    end
    power_pellet = 1'b0;
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    start = 1'b0;
    power_pellet = 1'b0;
    pacX = 10'd48;
    pacY = 10'd300;
    ghostX = 10'd49;
    ghostY = 10'd48;
    test_reset();
    test_mode_cycle();
    test_chase_greedy();
    test_border();
    test_fright();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
